// File: rtl/ponte_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// ponte_cmd_if
// Command handshake between the bridge sequencer and the zoom coprocessor.
//   cmd_valid   : sequencer -> coprocessor, command is being offered
//   cmd_ready   : coprocessor -> sequencer, command accepted this cycle
//   cmd_opcode  : sequencer -> coprocessor, 4-bit opcode of the command
//   cmd_operand : sequencer -> coprocessor, 10-bit operand of the command
//   op_done     : coprocessor -> sequencer, single-cycle completion pulse
// master = sequencer side, slave = coprocessor side.
// ---------------------------------------------------------------------------
interface ponte_cmd_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_opcode;
  logic [9:0] cmd_operand;
  logic       op_done;

  modport master (
    output cmd_valid,
    output cmd_opcode,
    output cmd_operand,
    input  cmd_ready,
    input  op_done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_opcode,
    input  cmd_operand,
    output cmd_ready,
    output op_done
  );
endinterface

// File: rtl/ponte_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// ponte_cmd_sequencer
// Fabric-side controller for the 15-bit HPS-to-FPGA command bridge PIO.
// A new command is recognised when the request toggle in the bridge word
// differs from the ack toggle reported back to the HPS. The command is
// offered to the coprocessor on a valid/ready handshake, completion is
// awaited with a timeout, and the outcome is reported on an 8-bit status.
//
// Ports:
//   clk      : system clock (bridge PIO and coprocessor share this domain)
//   reset_n  : asynchronous, active-low reset
//   pio_word : [14] request toggle, [13:10] opcode, [9:0] operand
//   cmd      : command handshake to the coprocessor (master modport)
//   status   : [0] busy, [1] ack toggle, [2] error, [3] timeout,
//              [7:4] last accepted opcode
// ---------------------------------------------------------------------------
module ponte_cmd_sequencer #(
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [15:0] VALID_OP_MASK  = 16'h00FF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [14:0]   pio_word,
  ponte_cmd_if.master   cmd,
  output logic [7:0]    status
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    REPORT    = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic             tog_q,     tog_d;      // toggle captured with the command
  logic             ack_q,     ack_d;      // toggle acknowledged to the HPS
  logic             busy_q,    busy_d;
  logic             err_q,     err_d;
  logic             to_q,      to_d;
  logic [3:0]       last_op_q, last_op_d;
  logic [3:0]       opc_q,     opc_d;
  logic [9:0]       opr_q,     opr_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  // Level compare: a toggle that flips twice while busy is not seen.
  logic req_new;
  logic op_legal;
  logic at_limit;

  assign req_new  = (pio_word[14] != ack_q);
  assign op_legal = VALID_OP_MASK[pio_word[13:10]];
  assign at_limit = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_new) begin
          state_d = op_legal ? ISSUE : REPORT;
        end
      end
      ISSUE: begin
        if (cmd.cmd_ready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (cmd.op_done || at_limit) begin
          state_d = REPORT;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values (command capture, flags, timeout counter)
  always_comb begin
    tog_d     = tog_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
    err_d     = err_q;
    to_d      = to_q;
    last_op_d = last_op_q;
    opc_d     = opc_q;
    opr_d     = opr_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_new) begin
          tog_d     = pio_word[14];
          opc_d     = pio_word[13:10];
          opr_d     = pio_word[9:0];
          last_op_d = pio_word[13:10];
          busy_d    = 1'b1;
          to_d      = 1'b0;
          err_d     = !op_legal;
        end
      end
      ISSUE: begin
        if (cmd.cmd_ready) begin
          cnt_d = '0;
        end
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Completion in the terminal cycle takes precedence over the abort.
        if (!cmd.op_done && at_limit) begin
          err_d = 1'b1;
          to_d  = 1'b1;
        end
      end
      REPORT: begin
        ack_d  = tog_q;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tog_q     <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      to_q      <= 1'b0;
      last_op_q <= 4'd0;
      opc_q     <= 4'd0;
      opr_q     <= 10'd0;
      cnt_q     <= '0;
    end else begin
      tog_q     <= tog_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      to_q      <= to_d;
      last_op_q <= last_op_d;
      opc_q     <= opc_d;
      opr_q     <= opr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Outputs: cmd_valid is a pure function of the state, so it drops
  // together with the state register on reset.
  always_comb begin
    cmd.cmd_valid   = (state_q == ISSUE);
    cmd.cmd_opcode  = opc_q;
    cmd.cmd_operand = opr_q;
    status          = {last_op_q, to_q, err_q, ack_q, busy_q};
  end

endmodule

// File: tb/tb_ponte_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ponte_cmd_sequencer
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a transaction-level model of the bridge protocol, with literal
// status values pinned at the key points of the directed scenarios.
// ---------------------------------------------------------------------------
module tb_ponte_cmd_sequencer;
  localparam int          TO   = 16;
  localparam logic [15:0] MASK = 16'h00FF;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic [14:0] pio_word = 15'd0;
  logic [7:0]  status;

  ponte_cmd_if cif();

  ponte_cmd_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .VALID_OP_MASK (MASK)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pio_word(pio_word),
    .cmd     (cif),
    .status  (status)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int vcount = 0;
  logic tog_w = 1'b0;

  // Model of the bridge as seen by the HPS and the coprocessor.
  logic       m_ack, m_busy, m_err, m_to, m_tog;
  logic [3:0] m_last, m_op;
  logic [9:0] m_operand;
  logic       m_offering;   // command currently offered to the coprocessor
  logic       m_waiting;    // accepted, awaiting completion
  logic       m_reporting;  // outcome being handed back this cycle
  int         m_waited;     // completion-wait cycles already elapsed

  function automatic logic [7:0] m_status();
    return {m_last, m_to, m_err, m_ack, m_busy};
  endfunction

  task automatic model_reset();
    m_ack = 0; m_busy = 0; m_err = 0; m_to = 0; m_tog = 0;
    m_last = 0; m_op = 0; m_operand = 0;
    m_offering = 0; m_waiting = 0; m_reporting = 0; m_waited = 0;
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    if (m_reporting) begin
      m_ack = m_tog;
      m_busy = 0;
      m_reporting = 0;
    end else if (m_waiting) begin
      if (cif.op_done) begin
        m_waiting = 0;
        m_reporting = 1;
      end else if (m_waited + 1 == TO) begin
        m_err = 1; m_to = 1;
        m_waiting = 0;
        m_reporting = 1;
      end else begin
        m_waited = m_waited + 1;
      end
    end else if (m_offering) begin
      if (cif.cmd_ready) begin
        m_offering = 0;
        m_waiting = 1;
        m_waited = 0;
      end
    end else if (!m_busy && pio_word[14] != m_ack) begin
      m_tog = pio_word[14];
      m_op = pio_word[13:10];
      m_operand = pio_word[9:0];
      m_last = pio_word[13:10];
      m_busy = 1;
      m_to = 0;
      if (MASK[pio_word[13:10]]) begin
        m_err = 0;
        m_offering = 1;
      end else begin
        m_err = 1;
        m_reporting = 1;
      end
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    cmp("cmd_valid",   {31'd0, cif.cmd_valid}, {31'd0, m_offering});
    cmp("cmd_opcode",  {28'd0, cif.cmd_opcode}, {28'd0, m_op});
    cmp("cmd_operand", {22'd0, cif.cmd_operand}, {22'd0, m_operand});
    cmp("status",      {24'd0, status}, {24'd0, m_status()});
    if (cif.cmd_valid === 1'b1) vcount++;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Run a command through handshake, completion and report (ready held high).
  task automatic finish_cmd();
    cif.cmd_ready = 1;
    tick();               // handshake
    cif.op_done = 1;
    tick();               // completion seen in first wait cycle
    cif.op_done = 0;
    tick();               // report
  endtask

  initial begin
    cif.cmd_ready = 0;
    cif.op_done   = 0;
    model_reset();

    // Reset state and quiet bus
    repeat (3) @(negedge clk);
    check_all();
    cmp("rst_status", {24'd0, status}, 32'h00);
    reset_n = 1;
    vcount = 0;
    repeat (10) tick();
    cmp("idle_status", {24'd0, status}, 32'h00);
    cmp("idle_vcount", vcount, 0);

    // Legal opcode 3, operand 200, done 5 cycles after handshake
    vcount = 0;
    pio_word = {1'b1, 4'd3, 10'd200};
    cif.cmd_ready = 1;
    tick();
    cmp("t2_busy", {24'd0, status}, 32'h31);
    cmp("t2_opc", {28'd0, cif.cmd_opcode}, 32'd3);
    cmp("t2_opr", {22'd0, cif.cmd_operand}, 32'd200);
    tick();
    repeat (4) tick();
    cif.op_done = 1;
    tick();
    cif.op_done = 0;
    cmp("t2_report", {24'd0, status}, 32'h31);
    tick();
    cmp("t2_done", {24'd0, status}, 32'h32);
    cmp("t2_vcount", vcount, 1);

    // Illegal opcode 9
    vcount = 0;
    pio_word = {1'b0, 4'd9, 10'd0};
    tick();
    cmp("t3_report", {24'd0, status}, 32'h97);
    tick();
    cmp("t3_done", {24'd0, status}, 32'h94);
    repeat (3) tick();
    cmp("t3_vcount", vcount, 0);

    // Ready held low for 20 cycles; payload changes on the bus are ignored
    vcount = 0;
    pio_word = {1'b1, 4'd5, 10'd77};
    cif.cmd_ready = 0;
    tick();
    pio_word[13:0] = {4'd2, 10'd1};
    repeat (20) tick();
    cif.cmd_ready = 1;
    tick();
    cmp("t4_vcount", vcount, 21);
    cif.op_done = 1;
    tick();
    cif.op_done = 0;
    tick();
    cmp("t4_done", {24'd0, status}, 32'h52);
    cmp("t4_opc", {28'd0, cif.cmd_opcode}, 32'd5);
    cmp("t4_opr", {22'd0, cif.cmd_operand}, 32'd77);

    // Timeout; op_done during the handshake cycle is ignored
    pio_word = {1'b0, 4'd1, 10'd5};
    cif.cmd_ready = 1;
    tick();
    cif.op_done = 1;
    tick();
    cif.op_done = 0;
    repeat (15) tick();
    cmp("t5_last_wait", {24'd0, status}, 32'h13);
    tick();
    cmp("t5_report", {24'd0, status}, 32'h1F);
    tick();
    cmp("t5_done", {24'd0, status}, 32'h1C);
    pio_word = {1'b1, 4'd2, 10'd9};
    tick();
    cmp("t5_next_clears", {24'd0, status}, 32'h21);
    finish_cmd();
    tick();
    cmp("t5_next_done", {24'd0, status}, 32'h22);

    // Reset during WAIT_DONE, then re-detect of the toggle left at 1
    pio_word = {1'b0, 4'd4, 10'd4};
    tick();
    finish_cmd();
    tick();
    cmp("t6_pre", {24'd0, status}, 32'h40);
    pio_word = {1'b1, 4'd6, 10'd300};
    tick();
    tick();
    #2 reset_n = 0;
    #1;
    cmp("t6_rst_status", {24'd0, status}, 32'h00);
    cmp("t6_rst_valid", {31'd0, cif.cmd_valid}, 32'd0);
    cmp("t6_rst_opc", {28'd0, cif.cmd_opcode}, 32'd0);
    model_reset();
    @(negedge clk);
    check_all();
    reset_n = 1;
    tick();
    cmp("t6_reissue", {24'd0, status}, 32'h61);
    cmp("t6_valid", {31'd0, cif.cmd_valid}, 32'd1);
    cmp("t6_opr", {22'd0, cif.cmd_operand}, 32'd300);
    finish_cmd();
    tick();
    cmp("t6_done", {24'd0, status}, 32'h62);
    tog_w = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cif.cmd_ready = ($urandom_range(0, 3) != 0);
      cif.op_done   = ($urandom_range(0, 7) == 0);
      if (!m_busy && m_ack == tog_w && $urandom_range(0, 2) == 0) begin
        tog_w = ~tog_w;
        pio_word = {tog_w, 4'($urandom_range(0, 15)), 10'($urandom_range(0, 1023))};
      end else if (m_busy && $urandom_range(0, 9) == 0) begin
        pio_word[13:0] = 14'($urandom);
      end else if (m_busy && $urandom_range(0, 299) == 0) begin
        tog_w = ~tog_w;
        pio_word[14] = tog_w;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ponte_cmd_sequencer.md
Name: ponte_cmd_sequencer

Overview:
- Fabric-side controller for the 15-bit HPS-to-FPGA command bridge PIO.
- Detects a new command from a toggle bit in the bridge word and decodes its opcode and operand.
- Issues the command to the zoom coprocessor over a valid/ready handshake, waits for completion with a timeout, and reports busy, ack, error and last opcode back to the HPS on an 8-bit status word (input PIO).

Parameters:
- TIMEOUT_CYCLES, 1000000, max cycles in WAIT_DONE before abort; counter width = $clog2(TIMEOUT_CYCLES)+1.
- VALID_OP_MASK, 16'h00FF, bit n = 1 means opcode n is legal.

Ports:
- clk  in  1  system clock; same domain as the bridge PIO and the coprocessor.
- reset_n  in  1  asynchronous, active-low reset.
- pio_word  in  15  bridge word: [14] request toggle, [13:10] opcode, [9:0] operand.
- cmd_valid  out  1  command valid to coprocessor.
- cmd_ready  in  1  coprocessor accepts command.
- cmd_opcode  out  4  captured opcode.
- cmd_operand  out  10  captured operand.
- op_done  in  1  single-cycle completion pulse from coprocessor.
- status  out  8  [0] busy, [1] ack toggle, [2] error, [3] timeout, [7:4] last accepted opcode.

Behaviour:
- Reset: clk is clk; reset reset_n is asynchronous, active-low. All of the following clear to 0: state = IDLE, cmd_valid, cmd_opcode, cmd_operand, ack toggle, error, timeout, last opcode, busy, timeout counter. status = 8'h00.
- Request detect: in IDLE, when pio_word[14] != ack toggle in cycle N:
  - capture opcode, operand and toggle value;
  - clear error and timeout;
  - set busy and last opcode = opcode, visible in cycle N+1.
- Request detect, legal opcode (VALID_OP_MASK[opcode] = 1): go to ISSUE; cmd_valid is high from cycle N+1.
- Request detect, illegal opcode: go to REPORT; set error = 1; cmd_valid is never asserted.
- ISSUE:
  - cmd_valid held high; cmd_opcode and cmd_operand held stable.
  - On cmd_valid && cmd_ready: cmd_valid drops next cycle, timeout counter clears, go to WAIT_DONE.
  - No timeout applies in ISSUE; cmd_valid is never withdrawn without a transfer.
- WAIT_DONE: counter increments every cycle.
  - op_done = 1: go to REPORT.
  - Counter == TIMEOUT_CYCLES-1 without op_done: set error = 1 and timeout = 1, go to REPORT.
  - op_done and the terminal count in the same cycle: op_done wins; no error.
- op_done outside WAIT_DONE, including the handshake cycle in ISSUE: ignored.
- REPORT (1 cycle): ack toggle <= captured toggle; busy <= 0; go to IDLE.
  - error, timeout and last opcode stay sticky until the next accepted request.
- Toggle changes while busy are not sampled. Detection is level-compare, so a double flip during busy is lost. HPS protocol: wait until status[1] == the written toggle before writing the next command.
- pio_word opcode and operand changes after capture have no effect on the in-flight command.
- Minimum turnaround, request to ack with cmd_ready and op_done immediate:
  - N detect, N+1 ISSUE handshake, N+2 WAIT with op_done, N+3 REPORT;
  - ack and busy = 0 visible at N+4.
- Reset mid-operation: immediate return to IDLE with all outputs 0. An HPS toggle left at 1 is re-detected after reset as a new request (ack = 0).

Test Plan:
- Reset, then pio_word = 15'h0000 for 10 cycles -> status = 8'h00, cmd_valid never high.
- Write {1, 4'd3, 10'd200}; cmd_ready = 1, op_done pulse 5 cycles after handshake -> cmd_opcode = 3, cmd_operand = 200 for exactly one valid cycle; status = 8'h31 while busy; status = 8'h32 after REPORT.
- Write {0, 4'd9, 10'd0} (opcode 9 illegal under the default mask) with ack = 1 -> cmd_valid never asserted; status = 8'h94 (error, ack = 0, last opcode 9) two cycles after write.
- Legal command, cmd_ready held low 20 cycles then high -> cmd_valid stays high 21 cycles with a stable payload; sequence completes normally.
- TIMEOUT_CYCLES = 16, op_done never asserted -> REPORT 16 cycles after handshake; status[3:2] = 2'b11; ack updated. Next command clears both flags.
- Assert reset_n = 0 during WAIT_DONE -> cmd_valid = 0 and status = 0 asynchronously. After release with pio_word[14] = 1, the command is re-issued.
